// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared glyph, anode and digit-index constants for the display path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

    // Shared with the number-entry block's dot_seg encoding
    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_THOUS = 2'd3;

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational nibble-to-glyph mapping with a forced-blank input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule : seg7_decode

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// Module   : seg7_scan
// Purpose  : Time-multiplexed 4-digit common-anode driver with per-frame
//            input shadowing, ghost-guard window and leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [1:0]  dot_seg,
    input  logic        blank_lead,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int         DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] C_GUARD   = DIV_W'(GUARD);

    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_digit_idx;
    logic [15:0]      r_shadow_data;
    logic [1:0]       r_shadow_dot;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [6:0]       w_glyph;
    logic             w_wrap;
    logic             w_frame_start;
    logic             w_zero_3;
    logic             w_zero_32;
    logic             w_zero_321;

    assign w_wrap        = (r_div_cnt == C_DIV_MAX);
    assign w_frame_start = (r_div_cnt == '0) && (r_digit_idx == DIG_ONES);

    // A digit is a leading zero when it and every digit above it are zero
    assign w_zero_3   = (r_shadow_data[15:12] == 4'h0);
    assign w_zero_32  = w_zero_3  && (r_shadow_data[11:8] == 4'h0);
    assign w_zero_321 = w_zero_32 && (r_shadow_data[7:4]  == 4'h0);

    always_comb begin
        w_nibble = r_shadow_data[3:0];
        w_blank  = 1'b0;
        case (r_digit_idx)
            DIG_ONES: begin
                w_nibble = r_shadow_data[3:0];
                w_blank  = 1'b0;
            end
            DIG_TENS: begin
                w_nibble = r_shadow_data[7:4];
                w_blank  = blank_lead && w_zero_321;
            end
            DIG_HUNDS: begin
                w_nibble = r_shadow_data[11:8];
                w_blank  = blank_lead && w_zero_32;
            end
            default: begin
                w_nibble = r_shadow_data[15:12];
                w_blank  = blank_lead && w_zero_3;
            end
        endcase
    end

    seg7_decode u_decode (
        .nibble (w_nibble),
        .blank  (w_blank),
        .seg    (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_digit_idx   <= DIG_ONES;
            r_shadow_data <= 16'h0000;
            r_shadow_dot  <= DIG_ONES;
            r_an          <= AN_OFF;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
        end else begin
            if (w_wrap) begin
                r_div_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_div_cnt   <= r_div_cnt + 1'b1;
            end

            if (w_frame_start) begin
                r_shadow_data <= data;
                r_shadow_dot  <= dot_seg;
            end

            // The guard also masks the reload cycle, so stale shadow never shows
            if (r_div_cnt < C_GUARD) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(4'b0001 << r_digit_idx);
                r_seg <= w_glyph;
                r_dp  <= (r_digit_idx != r_shadow_dot);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule : seg7_scan

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Self-checking bench for seg7_scan with SCAN_DIV=4, GUARD=1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [1:0]  dot_seg;
    logic        blank_lead;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan #(.SCAN_DIV(4), .GUARD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dot_seg    (dot_seg),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  dot;
        logic        bl;
        logic [27:0] segs;   // {d3,d2,d1,d0} expected glyphs
    } vec_t;

    vec_t vecs [8];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   e      = 0;   // edges since last reset release
    int   jj     = 0;   // frame position of the latest sampled output

    task automatic tick();
        @(posedge clk);
        #1;
        jj = e % 16;
        e  = e + 1;
    endtask

    function automatic logic [11:0] expect_out(int j, logic [27:0] segs, logic [1:0] dot);
        int d;
        logic [3:0] a;
        if (j % 4 == 0) return {4'hF, 7'h7F, 1'b1};
        d = j / 4;
        a = ~(4'b0001 << d);
        return {a, segs[d*7 +: 7], (d[1:0] == dot) ? 1'b0 : 1'b1};
    endfunction

    task automatic check(string name, logic [11:0] exp);
        n_vec = n_vec + 1;
        if ({an, seg, dp} !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s j=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                     name, jj, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic goto_end_of_frame();
        while (jj != 15) tick();
    endtask

    // One whole frame; optionally change inputs after the given position
    task automatic run_frame(string name, logic [27:0] segs, logic [1:0] dot,
                             int chg_j, logic [15:0] chg_data, logic [1:0] chg_dot);
        for (int k = 0; k < 16; k++) begin
            tick();
            check(name, expect_out(jj, segs, dot));
            if (jj == chg_j) begin
                data    = chg_data;
                dot_seg = chg_dot;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h1234, 2'd0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0040, 2'd0, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}};
        vecs[2] = '{16'h0000, 2'd0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0400, 2'd0, 1'b1, {7'h7F, 7'h19, 7'h40, 7'h40}};
        vecs[4] = '{16'hABCD, 2'd3, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[5] = '{16'h5678, 2'd2, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[6] = '{16'h9E0F, 2'd1, 1'b1, {7'h10, 7'h06, 7'h40, 7'h0E}};
        vecs[7] = '{16'h0000, 2'd1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};

        // Reset held for three cycles
        rst = 1'b1; data = 16'h1234; dot_seg = 2'd2; blank_lead = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset", {4'hF, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        e   = 0;
        tick();
        check("post_reset_guard", {4'hF, 7'h7F, 1'b1});

        for (int v = 0; v < 8; v++) begin
            goto_end_of_frame();
            data = vecs[v].data; dot_seg = vecs[v].dot; blank_lead = vecs[v].bl;
            run_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dot, -1, 16'h0, 2'd0);
        end

        // Anti-tearing: data changes during the digit-1 slot
        goto_end_of_frame();
        data = 16'h1234; dot_seg = 2'd0; blank_lead = 1'b0;
        run_frame("tear_old", {7'h79, 7'h24, 7'h30, 7'h19}, 2'd0, 5, 16'h5678, 2'd0);
        run_frame("tear_new", {7'h12, 7'h02, 7'h78, 7'h00}, 2'd0, -1, 16'h0, 2'd0);

        // Dot moves only at the next frame
        goto_end_of_frame();
        data = 16'hABCD; dot_seg = 2'd3;
        run_frame("dot_old", {7'h08, 7'h03, 7'h46, 7'h21}, 2'd3, 6, 16'hABCD, 2'd1);
        run_frame("dot_new", {7'h08, 7'h03, 7'h46, 7'h21}, 2'd1, -1, 16'h0, 2'd0);

        // Live blank_lead: the shadow keeps leading zeros, blanking follows the pin
        goto_end_of_frame();
        data = 16'h0040; dot_seg = 2'd0; blank_lead = 1'b0;
        run_frame("bl_off", {7'h40, 7'h40, 7'h19, 7'h40}, 2'd0, 7, 16'h0040, 2'd0);

        // Reset during the digit-2 active window
        goto_end_of_frame();
        data = 16'h1234; dot_seg = 2'd0; blank_lead = 1'b0;
        while (jj != 9) tick();
        check("pre_mid_reset", expect_out(9, {7'h79, 7'h24, 7'h30, 7'h19}, 2'd0));
        rst = 1'b1; data = 16'h0009; dot_seg = 2'd0;
        tick();
        check("mid_reset", {4'hF, 7'h7F, 1'b1});
        rst = 1'b0;
        e   = 0;
        run_frame("after_reset", {7'h40, 7'h40, 7'h40, 7'h10}, 2'd0, -1, 16'h0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan

`default_nettype wire
